// File: rtl/sq_layer_pkg.sv
// ---------------------------------------------------------------------------
// sq_layer_pkg
// Shared types, widths and the requantisation function for the squeeze/expand
// pointwise convolution engine (pw_conv_layer and its pw_mac_lane lanes).
//
// WIDTH and FRAC_SHIFT live here rather than as top-level parameters because
// word_t / acc_t and requant() are built from them.
//
// The accumulator is sized for CHIN_MAX input channels. Smaller CHIN values
// therefore get a few spare sign bits. Because the sum never overflows, this
// gives the same numeric result as an exactly sized accumulator.
//
// Optional feature macro: PW_CONV_SATURATE_EN
//   defined   -> requant() saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1]
//   undefined -> requant() truncates (wraps on overflow)
// ---------------------------------------------------------------------------
package sq_layer_pkg;

    localparam int WIDTH      = 16;
    localparam int FRAC_SHIFT = 14;
    localparam int CHIN_MAX   = 64;

    function automatic int acc_width(input int w, input int chin);
        return 2 * w + $clog2(chin);
    endfunction

    localparam int ACC_W = acc_width(WIDTH, CHIN_MAX);

    typedef logic signed [WIDTH-1:0]   word_t;
    typedef logic signed [2*WIDTH-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]   acc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Takes the biased accumulator s and returns one output word.
    // The result is {sign of s, s[FRAC_SHIFT+WIDTH-2:FRAC_SHIFT]}. The sign bit
    // is taken from the top of the accumulator rather than from the
    // extracted field, so an overflowing positive sum wraps and keeps a
    // positive sign.
    function automatic word_t requant(input acc_t s, input bit relu);
        acc_t  q;
        word_t r;
        q = s >>> FRAC_SHIFT;
        r = {q[ACC_W-1], q[WIDTH-2:0]};
`ifdef PW_CONV_SATURATE_EN
        if (q > ((acc_t'(1) <<< (WIDTH-1)) - acc_t'(1)))
            r = {1'b0, {(WIDTH-1){1'b1}}};
        else if (q < -(acc_t'(1) <<< (WIDTH-1)))
            r = {1'b1, {(WIDTH-1){1'b0}}};
`endif
        if (relu && s[ACC_W-1])
            r = '0;
        return r;
    endfunction

endpackage

// File: rtl/pw_mac_lane.sv
// ---------------------------------------------------------------------------
// pw_mac_lane
// One output-channel MAC lane of the pointwise convolution engine.
// Stage 1 registers the accepted activation and weight.
// Stage 2 multiplies them and either loads the accumulator (channel 0) or
// adds to it.
//
// Ports
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset
//   i_en        word accepted this cycle; capture i_ifm / i_weight
//   i_ifm       activation word
//   i_weight    this lane's weight word
//   i_acc_en    stage-1 registers hold a valid word; update accumulator
//   i_acc_load  that word is channel 0; load the product instead of adding
//   o_acc       running accumulator
// ---------------------------------------------------------------------------
module pw_mac_lane
    import sq_layer_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_en,
    input  word_t i_ifm,
    input  word_t i_weight,
    input  logic  i_acc_en,
    input  logic  i_acc_load,
    output acc_t  o_acc
);

    word_t r_ifm;
    word_t r_weight;
    acc_t  r_acc;
    prod_t w_prod;

    assign w_prod = r_ifm * r_weight;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ifm    <= '0;
            r_weight <= '0;
        end else if (i_en) begin
            r_ifm    <= i_ifm;
            r_weight <= i_weight;
        end
    end

    // Stalls leave i_acc_en low, so the partial sum is simply held.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_acc_en) begin
            if (i_acc_load)
                r_acc <= acc_t'(w_prod);
            else
                r_acc <= r_acc + acc_t'(w_prod);
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/pw_conv_layer.sv
// ---------------------------------------------------------------------------
// pw_conv_layer
// 1x1 (pointwise) convolution engine for the squeeze/expand fire layers.
// It accepts one input pixel-channel word per handshake, in channel-major
// order within each pixel. DSP_NO MAC lanes run in parallel. For each pixel
// it emits one biased, ReLU'd and requantised DSP_NO-wide output vector.
//
// State table
//   state | meaning
//   IDLE  | waiting for i_start
//   RUN   | accepting ifm words; counters advance on each accept
//   DRAIN | all words accepted; waiting for the pipe to empty and the last
//         | vector to be taken
//   DONE  | one cycle, o_done = 1
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start                   starts a run (only in IDLE)
//   i_ifm_valid / o_ifm_ready input word handshake
//   i_ifm                     activation word for pixel p, channel c
//   o_weight_addr             current channel index into the weight ROM
//   i_weight_data             combinational ROM data for o_weight_addr
//   i_bias                    per-lane bias (2*WIDTH each), static per run
//   o_ofm_valid / i_ofm_ready output vector handshake; valid is held until
//                             the vector is taken
//   o_ofm                     requantised output vector
//   o_busy                    state != IDLE
//   o_done                    one-cycle pulse at the end of a run
//
// Parameters: DSP_NO lanes, CHIN channels (4..CHIN_MAX), WOUT x WOUT pixels,
// RELU (1 clamps negative results to zero).
// Macro: PW_CONV_SATURATE_EN selects saturating requantisation
// (see sq_layer_pkg).
// ---------------------------------------------------------------------------
module pw_conv_layer
    import sq_layer_pkg::*;
#(
    parameter int DSP_NO = 256,
    parameter int CHIN   = 64,
    parameter int WOUT   = 16,
    parameter int RELU   = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic                      i_ifm_valid,
    output logic                      o_ifm_ready,
    input  logic [WIDTH-1:0]          i_ifm,
    output logic [$clog2(CHIN)-1:0]   o_weight_addr,
    input  logic [DSP_NO*WIDTH-1:0]   i_weight_data,
    input  logic [DSP_NO*2*WIDTH-1:0] i_bias,
    output logic                      o_ofm_valid,
    input  logic                      i_ofm_ready,
    output logic [DSP_NO*WIDTH-1:0]   o_ofm,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int NPIX  = WOUT * WOUT;
    localparam int CH_W  = $clog2(CHIN);
    localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHIN - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [CH_W-1:0]         r_ch_cnt;
    logic [PIX_W-1:0]        r_pix_cnt;
    logic                    r_v1;
    logic                    r_first1;
    logic                    r_last1;
    logic                    r_last2;
    logic                    r_ofm_valid;
    logic [DSP_NO*WIDTH-1:0] r_ofm;

    logic w_ifm_ready;
    logic w_accept;
    logic w_ch_last;
    logic w_pipe_empty;
    logic w_busy;
    logic w_done;

    acc_t  w_acc [DSP_NO];
    acc_t  w_s   [DSP_NO];
    word_t w_q   [DSP_NO];

    assign w_ch_last    = (r_ch_cnt == CH_LAST);
    assign w_accept     = i_ifm_valid && w_ifm_ready;
    assign w_pipe_empty = !r_v1 && !r_last2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Only one output buffer exists. The last channel of a pixel is held off
    // while a vector is still waiting downstream. The next write then cannot
    // land on an unread vector. With CHIN >= 4, any earlier write is already
    // visible in o_ofm_valid by the time this check is made.
    always_comb begin
        w_state_nxt = r_state;
        w_ifm_ready = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (i_start)
                    w_state_nxt = RUN;
            end
            RUN: begin
                w_ifm_ready = !(w_ch_last && r_ofm_valid && !i_ofm_ready);
                if (i_ifm_valid && w_ifm_ready && w_ch_last && (r_pix_cnt == PIX_LAST))
                    w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_pipe_empty && !r_ofm_valid)
                    w_state_nxt = DONE;
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ch_cnt  <= '0;
            r_pix_cnt <= '0;
        end else if (r_state == IDLE && i_start) begin
            r_ch_cnt  <= '0;
            r_pix_cnt <= '0;
        end else if (w_accept) begin
            if (w_ch_last) begin
                r_ch_cnt  <= '0;
                r_pix_cnt <= (r_pix_cnt == PIX_LAST) ? '0 : r_pix_cnt + 1'b1;
            end else begin
                r_ch_cnt <= r_ch_cnt + 1'b1;
            end
        end
    end

    // Control bits that travel alongside the lane data.
    // Stage 1 (r_v1, r_first1, r_last1) matches the lanes' operand registers.
    // Stage 2 (r_last2) marks the cycle in which the accumulators hold a
    // finished pixel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v1     <= 1'b0;
            r_first1 <= 1'b0;
            r_last1  <= 1'b0;
            r_last2  <= 1'b0;
        end else begin
            r_v1     <= w_accept;
            r_first1 <= w_accept && (r_ch_cnt == '0);
            r_last1  <= w_accept && w_ch_last;
            r_last2  <= r_v1 && r_last1;
        end
    end

    for (genvar g = 0; g < DSP_NO; g++) begin : g_lane
        pw_mac_lane u_lane (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_en       (w_accept),
            .i_ifm      (i_ifm),
            .i_weight   (i_weight_data[g*WIDTH +: WIDTH]),
            .i_acc_en   (r_v1),
            .i_acc_load (r_first1),
            .o_acc      (w_acc[g])
        );

        assign w_s[g] = w_acc[g] + acc_t'($signed(i_bias[g*2*WIDTH +: 2*WIDTH]));
        assign w_q[g] = requant(w_s[g], RELU != 0);
    end

    // A new vector takes priority over the clear. A write and a downstream
    // take in the same cycle therefore leave valid high for the new vector.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ofm       <= '0;
            r_ofm_valid <= 1'b0;
        end else if (r_last2) begin
            for (int g = 0; g < DSP_NO; g++)
                r_ofm[g*WIDTH +: WIDTH] <= w_q[g];
            r_ofm_valid <= 1'b1;
        end else if (r_ofm_valid && i_ofm_ready) begin
            r_ofm_valid <= 1'b0;
        end
    end

    assign o_ifm_ready   = w_ifm_ready;
    assign o_weight_addr = r_ch_cnt;
    assign o_ofm_valid   = r_ofm_valid;
    assign o_ofm         = r_ofm;
    assign o_busy        = w_busy;
    assign o_done        = w_done;

endmodule

// File: tb/tb_pw_conv_layer.sv
// ---------------------------------------------------------------------------
// tb_pw_conv_layer
// Two engines (RELU=1 and RELU=0) share one stimulus stream. Each result is
// compared with a reference computed from whole-pixel dot products using
// 64-bit integer arithmetic.
// ---------------------------------------------------------------------------
module tb_pw_conv_layer;

    localparam int DSP_NO = 2;
    localparam int CHIN   = 4;
    localparam int WOUT   = 2;
    localparam int NPIX   = WOUT * WOUT;
    localparam int TOT    = NPIX * CHIN;
    localparam int LIMIT  = 3000;

    logic                    i_clk = 1'b0;
    logic                    i_rst_n = 1'b0;
    logic                    i_start = 1'b0;
    logic                    i_ifm_valid = 1'b0;
    logic                    i_ofm_ready = 1'b0;
    logic [15:0]             i_ifm = '0;
    logic [DSP_NO*16-1:0]    i_weight_data;
    logic [DSP_NO*32-1:0]    i_bias;

    logic                    r_ifm_ready, l_ifm_ready;
    logic [1:0]              r_weight_addr, l_weight_addr;
    logic                    r_ofm_valid, l_ofm_valid;
    logic [DSP_NO*16-1:0]    r_ofm, l_ofm;
    logic                    r_busy, l_busy;
    logic                    r_done, l_done;

    shortint ifm_mem [NPIX][CHIN];
    shortint w_mem   [CHIN][DSP_NO];
    int      b_mem   [DSP_NO];

    logic [DSP_NO*16-1:0] q_relu [$];
    logic [DSP_NO*16-1:0] q_lin  [$];
    logic [DSP_NO*16-1:0] last_r, last_l;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    always_comb begin
        i_weight_data = '0;
        i_bias        = '0;
        for (int l = 0; l < DSP_NO; l++) begin
            i_weight_data[l*16 +: 16] = w_mem[r_weight_addr][l];
            i_bias[l*32 +: 32]        = b_mem[l];
        end
    end

    pw_conv_layer #(.DSP_NO(DSP_NO), .CHIN(CHIN), .WOUT(WOUT), .RELU(1)) dut_relu (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_ifm_valid(i_ifm_valid), .o_ifm_ready(r_ifm_ready), .i_ifm(i_ifm),
        .o_weight_addr(r_weight_addr), .i_weight_data(i_weight_data), .i_bias(i_bias),
        .o_ofm_valid(r_ofm_valid), .i_ofm_ready(i_ofm_ready), .o_ofm(r_ofm),
        .o_busy(r_busy), .o_done(r_done)
    );

    pw_conv_layer #(.DSP_NO(DSP_NO), .CHIN(CHIN), .WOUT(WOUT), .RELU(0)) dut_lin (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_ifm_valid(i_ifm_valid), .o_ifm_ready(l_ifm_ready), .i_ifm(i_ifm),
        .o_weight_addr(l_weight_addr), .i_weight_data(i_weight_data), .i_bias(i_bias),
        .o_ofm_valid(l_ofm_valid), .i_ofm_ready(i_ofm_ready), .o_ofm(l_ofm),
        .o_busy(l_busy), .o_done(l_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output word from the real-valued rule. out = floor(s / 2^14). The sign
    // bit comes from s itself and the low 15 bits come from the quotient.
    function automatic logic [15:0] ref_out(input longint s, input bit relu);
        longint q;
        if (relu && s < 0)
            return 16'h0000;
        q = s >>> 14;
`ifdef PW_CONV_SATURATE_EN
        if (q > 32767)
            return 16'h7fff;
        if (q < -32768)
            return 16'h8000;
`endif
        return {(s < 0), q[14:0]};
    endfunction

    task automatic build_expected();
        q_relu.delete();
        q_lin.delete();
        for (int p = 0; p < NPIX; p++) begin
            logic [DSP_NO*16-1:0] vr, vl;
            for (int l = 0; l < DSP_NO; l++) begin
                longint s;
                s = longint'(b_mem[l]);
                for (int c = 0; c < CHIN; c++)
                    s += longint'(ifm_mem[p][c]) * longint'(w_mem[c][l]);
                vr[l*16 +: 16] = ref_out(s, 1'b1);
                vl[l*16 +: 16] = ref_out(s, 1'b0);
            end
            q_relu.push_back(vr);
            q_lin.push_back(vl);
        end
    endtask

    task automatic fill_const(input shortint a, input shortint w, input int b);
        for (int p = 0; p < NPIX; p++)
            for (int c = 0; c < CHIN; c++)
                ifm_mem[p][c] = a;
        for (int c = 0; c < CHIN; c++)
            for (int l = 0; l < DSP_NO; l++)
                w_mem[c][l] = w;
        for (int l = 0; l < DSP_NO; l++)
            b_mem[l] = b;
    endtask

    task automatic fill_rand();
        for (int p = 0; p < NPIX; p++)
            for (int c = 0; c < CHIN; c++)
                ifm_mem[p][c] = shortint'($urandom);
        for (int c = 0; c < CHIN; c++)
            for (int l = 0; l < DSP_NO; l++)
                w_mem[c][l] = shortint'($urandom);
        for (int l = 0; l < DSP_NO; l++)
            b_mem[l] = int'($urandom) >>> $urandom_range(20);
    endtask

    // rdy_mode: 0 = always ready, 1 = random, 2 = held low for 20 cycles
    // early in the run.
    task automatic run_job(input int gap_pct, input int rdy_mode, input int abort_after,
                           input bit lat_chk, input string name);
        int  sent, it, done_cnt, last_iter;
        bit  prev_v, prev_hold, finished, lat_seen;
        logic [DSP_NO*16-1:0] prev_ofm, e;
        build_expected();
        sent = 0; it = 0; done_cnt = 0; last_iter = -100;
        prev_v = 0; prev_hold = 0; finished = 0; lat_seen = 0; prev_ofm = '0;
        @(negedge i_clk);
        i_start = 1'b1;
        while (it < LIMIT) begin
            @(negedge i_clk);
            i_start = 1'b0;
            it++;
            if (r_done) done_cnt++;
            if (prev_hold) begin
                chk({name, "_hold_valid"}, r_ofm_valid, 1);
                chk({name, "_hold_data"}, r_ofm, prev_ofm);
            end
            if (lat_chk && !lat_seen && sent == TOT && r_ofm_valid && !prev_v) begin
                lat_seen = 1;
                chk({name, "_latency"}, it - last_iter, 3);
            end
            if (done_cnt > 0 && !r_busy && !r_done) begin
                finished = 1;
                break;
            end
            case (rdy_mode)
                0:       i_ofm_ready = 1'b1;
                1:       i_ofm_ready = 1'($urandom_range(1));
                default: i_ofm_ready = !(it >= 8 && it < 28);
            endcase
            i_ifm_valid = (sent < TOT) && ($urandom_range(99) >= gap_pct);
            i_ifm = (sent < TOT) ? ifm_mem[sent / CHIN][sent % CHIN] : 16'($urandom);
            #1;
            if (r_ofm_valid && !i_ofm_ready && r_weight_addr == 2'(CHIN - 1))
                chk({name, "_ifm_ready_block"}, r_ifm_ready, 0);
            if (r_ofm_valid && i_ofm_ready) begin
                if (q_relu.size() == 0) begin
                    chk({name, "_extra_vector"}, 1, 0);
                end else begin
                    e = q_relu.pop_front();
                    chk({name, "_ofm_relu"}, r_ofm, e);
                    e = q_lin.pop_front();
                    chk({name, "_ofm_lin"}, l_ofm, e);
                    last_r = r_ofm;
                    last_l = l_ofm;
                end
            end
            prev_hold = r_ofm_valid && !i_ofm_ready;
            prev_ofm  = r_ofm;
            prev_v    = r_ofm_valid;
            if (i_ifm_valid && r_ifm_ready) begin
                sent++;
                if (sent == TOT) last_iter = it;
                if (abort_after > 0 && sent == abort_after) begin
                    @(posedge i_clk);
                    #2;
                    i_rst_n = 1'b0;
                    i_ifm_valid = 1'b0;
                    #1;
                    chk("abort_busy", r_busy, 0);
                    chk("abort_ofm_valid", r_ofm_valid, 0);
                    chk("abort_ofm_relu", r_ofm, 0);
                    chk("abort_ofm_lin", l_ofm, 0);
                    chk("abort_ifm_ready", r_ifm_ready, 0);
                    chk("abort_weight_addr", r_weight_addr, 0);
                    chk("abort_done", r_done, 0);
                    @(negedge i_clk);
                    @(negedge i_clk);
                    i_rst_n = 1'b1;
                    q_relu.delete();
                    q_lin.delete();
                    return;
                end
            end
        end
        i_ifm_valid = 1'b0;
        chk({name, "_finished"}, finished, 1);
        chk({name, "_done_pulses"}, done_cnt, 1);
        chk({name, "_vectors_left"}, q_relu.size(), 0);
        chk({name, "_words_sent"}, sent, TOT);
        if (lat_chk)
            chk({name, "_latency_seen"}, lat_seen, 1);
    endtask

    initial begin
        #12;
        chk("reset_busy", r_busy, 0);
        chk("reset_done", r_done, 0);
        chk("reset_ofm_valid", r_ofm_valid, 0);
        chk("reset_ofm", r_ofm, 0);
        chk("reset_ifm_ready", r_ifm_ready, 0);
        chk("reset_weight_addr", r_weight_addr, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // 1.0 * 0.25 over 4 channels = 1.0 -> 0x4000
        fill_const(16'sh4000, 16'sh1000, 0);
        run_job(0, 0, 0, 1'b1, "t1");
        chk("t1_value_relu", last_r[15:0], 16'h4000);
        chk("t1_value_lin", last_l[31:16], 16'h4000);

        // 1.0 * -0.25 over 4 channels = -1.0
        fill_const(16'sh4000, -16'sh1000, 0);
        run_job(0, 0, 0, 1'b0, "t2");
        chk("t2_value_relu", last_r[15:0], 16'h0000);
        chk("t2_value_lin", last_l[15:0], 16'hc000);

        // 1.0 * 1.0 over 4 channels = +4.0
        fill_const(16'sh4000, 16'sh4000, 0);
        run_job(0, 0, 0, 1'b0, "t4");
`ifdef PW_CONV_SATURATE_EN
        chk("t4_value_relu", last_r[15:0], 16'h7fff);
`else
        chk("t4_value_relu", last_r[15:0], 16'h0000);
`endif

        fill_rand();
        run_job(0, 2, 0, 1'b0, "t3");

        for (int k = 0; k < 3; k++) begin
            fill_rand();
            run_job(50, 1, 0, 1'b0, "t5");
        end

        fill_rand();
        run_job(0, 0, 6, 1'b0, "t6a");
        fill_rand();
        run_job(20, 1, 0, 1'b0, "t6b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
